// File: rtl/seq_pkg.sv
// +----------------------------------------------------------------------+
// | Module      : seq_pkg                                                |
// | Description : Shared types and constants for the serial sequence     |
// |               detector (FSM state encoding, reset configuration).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package seq_pkg;

  // Controller states; two bits leave one spare code that decodes to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Pattern loaded at reset (oldest bit in the MSB).
  localparam int unsigned         C_DEFAULT_PAT_W   = 5;
  localparam logic [C_DEFAULT_PAT_W-1:0] C_DEFAULT_PATTERN = 5'b10101;

  // Match limit loaded at reset: a single match ends the run.
  localparam int unsigned         C_DEFAULT_LIMIT   = 1;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/seq_matcher.sv
// +----------------------------------------------------------------------+
// | Module      : seq_matcher                                            |
// | Description : Serial shift register with fill counter and compare.   |
// |               match_o flags the bit being sampled this cycle as the  |
// |               completing bit of a match; hit_o is its registered     |
// |               copy and serves as the one-cycle match pulse.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_matcher
  import seq_pkg::*;
#(
  parameter int PAT_W = 5
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  input  logic             clear_i,    // run entry: empty the window
  input  logic             en_i,       // sample x_i this cycle
  input  logic             x_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             match_o,    // combinational, valid with en_i
  output logic             hit_o       // registered match pulse
);

  localparam int                FILL_W      = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] C_FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] C_FILL_LAST = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  seq_q;
  logic [PAT_W-1:0]  seq_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic              hit_q;

  // Next window contents and match decision for the bit sampled now;
  // matches are blocked until the window has been completely filled.
  always_comb begin
    seq_d   = {seq_q[PAT_W-2:0], x_i};
    fill_d  = (fill_q == C_FILL_FULL) ? fill_q : fill_q + 1'b1;
    match_o = en_i && (fill_q >= C_FILL_LAST) && (seq_d == pattern_i);
  end

  // Window, fill count and match pulse; the window is kept on a match so
  // overlapping occurrences are found.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seq_q  <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
    end else if (clear_i) begin
      seq_q  <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      hit_q <= match_o;
      if (en_i) begin
        seq_q  <= seq_d;
        fill_q <= fill_d;
      end
    end
  end

  assign hit_o = hit_q;

endmodule : seq_matcher

`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
// +----------------------------------------------------------------------+
// | Module      : seq_detect_ctrl                                        |
// | Description : Configurable serial pattern detector with run control, |
// |               match counting and limit-terminated runs.              |
// |               Optional no-match timeout enabled by SEQ_TIMEOUT_EN;   |
// |               without it the timeout port is tied low.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_detect_ctrl
  import seq_pkg::*;
#(
  parameter int PAT_W   = 5,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,          // synchronous, active-low
  input  logic             x,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             start,
  input  logic             abort,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  state_e           state_q;
  logic [PAT_W-1:0] pattern_q;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic [CNT_W-1:0] match_cnt_d;
  logic             busy_q;
  logic             cfg_ready_q;
  logic             done_q;

  logic             mat_clear;
  logic             mat_en;
  logic             mat_match;
  logic             mat_hit;
  logic             limit_hit;
  logic             tmo_expire;

  // The matcher is emptied on run entry and samples x only in RUN; an
  // abort suppresses the sample so a coincident match is neither counted
  // nor pulsed.
  assign mat_clear = (state_q == ST_IDLE) && start;
  assign mat_en    = (state_q == ST_RUN) && !abort;

  seq_matcher #(
    .PAT_W (PAT_W)
  ) u_matcher (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (mat_clear),
    .en_i      (mat_en),
    .x_i       (x),
    .pattern_i (pattern_q),
    .match_o   (mat_match),
    .hit_o     (mat_hit)
  );

  // Saturating match count and the limit test it feeds (limit 0 = endless).
  always_comb begin
    match_cnt_d = (&match_cnt_q) ? match_cnt_q : match_cnt_q + 1'b1;
    limit_hit   = (limit_q != '0) && (match_cnt_d == limit_q);
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int               TMR_W       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] C_TMR_LIMIT = TMR_W'(TIMEOUT);

  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic             timeout_q;

  // Cycles since run entry or the last match, including this one.
  always_comb begin
    timer_d    = timer_q + 1'b1;
    tmo_expire = (timer_d == C_TMR_LIMIT);
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_param;

  assign tmo_expire           = 1'b0;
  assign timeout              = 1'b0;
  assign unused_timeout_param = (TIMEOUT == 0);
`endif

  // Control FSM with configuration capture; every output is a register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pattern_q   <= PAT_W'(C_DEFAULT_PATTERN);
      limit_q     <= CNT_W'(C_DEFAULT_LIMIT);
      match_cnt_q <= '0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      done_q      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      timer_q     <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      // cfg_ready_q is high exactly in IDLE, so offers elsewhere stall.
      if (cfg_valid && cfg_ready_q) begin
        pattern_q <= cfg_pattern;
        limit_q   <= cfg_limit;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            cfg_ready_q <= 1'b0;
            match_cnt_q <= '0;
`ifdef SEQ_TIMEOUT_EN
            timer_q     <= '0;
`endif
          end
        end

        ST_RUN: begin
          if (abort) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
          end else if (mat_match) begin
            match_cnt_q <= match_cnt_d;
`ifdef SEQ_TIMEOUT_EN
            timer_q     <= '0;
`endif
            if (limit_hit) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
            end
          end else if (tmo_expire) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
            timeout_q   <= 1'b1;
            timer_q     <= '0;
`endif
          end else begin
`ifdef SEQ_TIMEOUT_EN
            timer_q <= timer_d;
`endif
          end
        end

        ST_DONE: begin
          state_q     <= ST_IDLE;
          done_q      <= 1'b1;
          cfg_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign z         = mat_hit;
  assign match_cnt = match_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule : seq_detect_ctrl

`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
// +----------------------------------------------------------------------+
// | Module      : tb_seq_detect_ctrl                                     |
// | Description : Directed self-checking bench for seq_detect_ctrl.      |
// |               The timeout scenario is selected by SEQ_TIMEOUT_EN.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_seq_detect_ctrl;

  localparam int PAT_W   = 5;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             x;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_limit;
  logic             start;
  logic             abort;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  seq_detect_ctrl #(
    .PAT_W   (PAT_W),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_limit   (cfg_limit),
    .start       (start),
    .abort       (abort),
    .z           (z),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs are read and inputs changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; x = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_limit = '0;
    start = 1'b0; abort = 1'b0;
    tick(); tick();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b exp 1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL reset_z: got %b exp 0", z); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b exp 0", timeout); end
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_match_cnt: got %0d exp 0", match_cnt); end
    rst = 1'b1;
    tick();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b exp 1", cfg_ready); end
  endtask

  // Default pattern 10101, limit 1: z after 5th bit, done one cycle later.
  task automatic test_single_match();
    logic [4:0] bits;
    bits = 5'b10101;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", busy); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL single_cfg_ready: got %b exp 0", cfg_ready); end
    for (int i = 0; i < 5; i++) begin
      x = bits[4-i];
      tick();
      checks++; if (z !== (i == 4)) begin errors++; $display("FAIL single_z bit%0d: got %b exp %b", i, z, (i == 4)); end
    end
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt: got %0d exp 1", match_cnt); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b exp 0", done); end
    x = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b exp 1", done); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL single_z_after: got %b exp 0", z); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b exp 0", done); end
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt_hold: got %0d exp 1", match_cnt); end
  endtask

  // Limit 3, stream 1010101010101: overlapping hits after bits 5, 7, 9.
  task automatic test_overlap();
    logic [12:0] bits;
    int          exp_cnt;
    bits = 13'b1010101010101;
    cfg_valid = 1'b1; cfg_pattern = 5'b10101; cfg_limit = 8'd3; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      x = bits[12-i];
      tick();
      exp_cnt = (i < 4) ? 0 : (i - 4) / 2 + 1;
      checks++; if (z !== (i >= 4 && (i % 2) == 0)) begin errors++; $display("FAIL overlap_z bit%0d: got %b", i, z); end
      checks++; if (match_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL overlap_cnt bit%0d: got %0d exp %0d", i, match_cnt, exp_cnt); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overlap_busy: got %b exp 0", busy); end
    for (int i = 9; i < 13; i++) begin
      x = bits[12-i];
      tick();
      checks++; if (done !== (i == 9)) begin errors++; $display("FAIL overlap_done bit%0d: got %b exp %b", i, done, (i == 9)); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL overlap_z_late bit%0d: got %b exp 0", i, z); end
      checks++; if (match_cnt !== 8'd3) begin errors++; $display("FAIL overlap_cnt_hold bit%0d: got %0d exp 3", i, match_cnt); end
    end
  endtask

  // Pattern 11100, unlimited, 20 bits then abort: busy drops, no done.
  task automatic test_abort_run();
    cfg_valid = 1'b1; cfg_pattern = 5'b11100; cfg_limit = 8'd0; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      x = ((i % 5) < 3);
      tick();
      checks++; if (z !== ((i % 5) == 4)) begin errors++; $display("FAIL abort_run_z bit%0d: got %b", i, z); end
      checks++; if (match_cnt !== CNT_W'((i + 1) / 5)) begin errors++; $display("FAIL abort_run_cnt bit%0d: got %0d exp %0d", i, match_cnt, (i + 1) / 5); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_run_busy: got %b exp 1", busy); end
    abort = 1'b1; x = 1'b0;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_run_busy_drop: got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_run_done: got %b exp 0", done); end
    checks++; if (match_cnt !== 8'd4) begin errors++; $display("FAIL abort_run_cnt_abort: got %0d exp 4", match_cnt); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_run_done_late: got %b exp 0", done); end
    checks++; if (match_cnt !== 8'd4) begin errors++; $display("FAIL abort_run_cnt_hold: got %0d exp 4", match_cnt); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_run_ready: got %b exp 1", cfg_ready); end
  endtask

  // Abort on the completing bit of the final (2nd) match: no z, no done.
  task automatic test_abort_on_match();
    logic [6:0] bits;
    bits = 7'b1010101;
    cfg_valid = 1'b1; cfg_pattern = 5'b10101; cfg_limit = 8'd2; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      x = bits[6-i];
      tick();
      checks++; if (z !== (i == 4)) begin errors++; $display("FAIL abort_match_z bit%0d: got %b exp %b", i, z, (i == 4)); end
    end
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL abort_match_cnt1: got %0d exp 1", match_cnt); end
    x = bits[0]; abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL abort_match_z_final: got %b exp 0", z); end
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL abort_match_cnt: got %0d exp 1", match_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_match_busy: got %b exp 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_match_done: got %b exp 0", done); end
  endtask

  // Config offered mid-run stalls until IDLE, then takes effect.
  task automatic test_cfg_stall();
    start = 1'b1; tick(); start = 1'b0;
    cfg_valid = 1'b1; cfg_pattern = 5'b11111; cfg_limit = 8'd1;
    for (int i = 0; i < 6; i++) begin
      x = 1'b1;
      tick();
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc%0d: got %b exp 0", i, cfg_ready); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL stall_z cyc%0d: got %b exp 0", i, z); end
    end
    abort = 1'b1; x = 1'b0;
    tick();
    abort = 1'b0;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_idle: got %b exp 1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x = 1'b1;
      tick();
      checks++; if (z !== (i == 4)) begin errors++; $display("FAIL stall_newcfg_z bit%0d: got %b exp %b", i, z, (i == 4)); end
    end
    x = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_newcfg_done: got %b exp 1", done); end
    tick();
  endtask

`ifdef SEQ_TIMEOUT_EN
  // Constant x=0 never matches 11111: timeout after TIMEOUT RUN cycles.
  task automatic test_timeout();
    x = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (timeout !== (i == 10)) begin errors++; $display("FAIL timeout_pulse cyc%0d: got %b exp %b", i, timeout, (i == 10)); end
      checks++; if (busy !== (i < 10)) begin errors++; $display("FAIL timeout_busy cyc%0d: got %b exp %b", i, busy, (i < 10)); end
    end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle: got %b exp 1", cfg_ready); end
    tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle: got %b exp 0", timeout); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL timeout_done: got %b exp 0", done); end
  endtask
`else
  // Without the timer, a long no-match run never times out.
  task automatic test_timeout();
    x = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_tied cyc%0d: got %b exp 0", i, timeout); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy cyc%0d: got %b exp 1", i, busy); end
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_abort_busy: got %b exp 0", busy); end
  endtask
`endif

  // Reset mid-run: run dropped silently, defaults restored.
  task automatic test_reset_mid_run();
    logic [4:0] bits;
    bits = 5'b10101;
    cfg_valid = 1'b1; cfg_pattern = 5'b00111; cfg_limit = 8'd0; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x = (i > 1);
      tick();
    end
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_pre_cnt: got %0d exp 1", match_cnt); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d exp 0", match_cnt); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL rstmid_z: got %b exp 0", z); end
    tick();
    checks++; if (done !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rstmid_pulse: got done=%b timeout=%b exp 0", done, timeout); end
    // Default pattern 10101 with limit 1 must be back in force.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x = bits[4-i];
      tick();
    end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL rstmid_default_z: got %b exp 1", z); end
    x = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_default_done: got %b exp 1", done); end
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_overlap();
    test_abort_run();
    test_abort_on_match();
    test_cfg_stall();
    test_timeout();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_detect_ctrl

`default_nettype wire

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 5, pattern width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, match-counter and limit width.
REQ-003 SHALL have parameter TIMEOUT, default 255, no-match cycle limit (used only under SEQ_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low (asserted when 0).
REQ-006 SHALL have port x  input  1  serial data bit, sampled every RUN cycle.
REQ-007 SHALL have port cfg_valid  input  1  configuration offer.
REQ-008 SHALL have port cfg_ready  output  1  configuration accept, high only in IDLE.
REQ-009 SHALL have port cfg_pattern  input  PAT_W  target pattern, MSB = oldest bit.
REQ-010 SHALL have port cfg_limit  input  CNT_W  match count ending a run; 0 = unlimited.
REQ-011 SHALL have port start  input  1  single-cycle run request.
REQ-012 SHALL have port abort  input  1  terminate run.
REQ-013 SHALL have port z  output  1  one-cycle match pulse.
REQ-014 SHALL have port match_cnt  output  CNT_W  matches in current or last run.
REQ-015 SHALL have port busy  output  1  high in RUN.
REQ-016 SHALL have port done  output  1  one-cycle pulse, limit reached.
REQ-017 SHALL have port timeout  output  1  one-cycle pulse, run ended by timeout.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE; registered outputs only.
REQ-019 SHALL transfer config when cfg_valid && cfg_ready, latching cfg_pattern and cfg_limit; cfg_valid outside IDLE stalls.
REQ-020 SHALL move IDLE->RUN on start (config transfer and start in same cycle: new config applies to that run); start outside IDLE ignored.
REQ-021 SHALL, on IDLE->RUN, clear the shift register, fill counter and match_cnt.
REQ-022 SHALL, each RUN cycle, shift x in as {seq[PAT_W-2:0], x}.
REQ-023 SHALL suppress matches until PAT_W bits have been shifted in since RUN entry.
REQ-024 SHALL assert z for exactly one cycle following the edge that samples the completing bit; overlapping matches count (shift register not cleared on match).
REQ-025 SHALL increment match_cnt per match, saturating at all-ones.
REQ-026 SHALL go RUN->DONE on the edge where match_cnt reaches nonzero cfg_limit; DONE drives done=1 for one cycle, then IDLE.
REQ-027 SHALL go RUN->IDLE on abort without done; abort wins over a simultaneous match (not counted, no z).
REQ-028 SHALL hold match_cnt in IDLE/DONE until next run start.
REQ-029 SHALL ignore x, start and abort in DONE.

Reset
REQ-030 SHALL, on rst=0 at a clock edge: state IDLE, pattern = PAT_W'b10101 (default), limit = 1, shift register/fill/timer = 0, z=0, done=0, timeout=0, busy=0, match_cnt=0, cfg_ready=1 after release.
REQ-031 SHALL abort any run on reset mid-operation, no done/timeout pulse.

Configuration
REQ-032 SHALL, with SEQ_TIMEOUT_EN defined, count RUN cycles since the last match or RUN entry, and on reaching TIMEOUT pulse timeout for one cycle and return to IDLE; a match on that edge wins (counter reloads).
REQ-033 SHALL, without SEQ_TIMEOUT_EN, keep the timeout port and tie it to 0, with no timer logic.

Structure
REQ-034 SHALL place FSM state enum and default pattern constant in shared package seq_pkg.
REQ-035 SHALL instantiate one sub-module seq_matcher (shift register, fill counter, registered compare) controlled by clear/enable from the FSM.

Verification
REQ-036 SHALL cover: reset, start, limit=1, x=1,0,1,0,1 -> z high cycle after 5th bit, done next cycle, match_cnt=1.
REQ-037 SHALL cover: limit=3, x=1010101010101 -> overlapping matches, z pulses after bits 5,7,9, done after third, match_cnt=3.
REQ-038 SHALL cover: pattern 5'b11100, limit 0, 20 cycles then abort -> busy drops next cycle, no done, match_cnt holds.
REQ-039 SHALL cover: abort on same cycle as completing bit of final match -> no z, no done, match_cnt unchanged.
REQ-040 SHALL cover: cfg_valid during RUN -> cfg_ready=0 until IDLE, then accepted.
REQ-041 SHALL cover with SEQ_TIMEOUT_EN, TIMEOUT=10: constant x=0 -> timeout pulse after 10 RUN cycles, IDLE.
